// File: rtl/voice_allocator.sv
// voice_allocator: accepts note-on/note-off commands, picks a voice slot
// (retrigger, free voice, or round-robin steal) and issues the matching
// register writes on a slow strobed byte bus.
//
// Ports:
//   Clock, Reset         rising-edge clock, synchronous active-high reset
//   NoteValid/NoteReady  command handshake (ready only while idle)
//   NoteOn/NoteKey/NoteIncr  command payload
//   BusAddress/BusWriteData/BusReadWrite/BusClock  voice register bus
//   VoiceActive          per-voice gate-open flags
module voice_allocator #(
  parameter int unsigned NUM_VOICES   = 4,
  parameter logic [15:0] VOICE_BASE   = 16'h0010,
  parameter logic [15:0] VOICE_STRIDE = 16'h0020,
  parameter int unsigned BUS_HALF     = 2
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  NoteValid,
  output logic                  NoteReady,
  input  logic                  NoteOn,
  input  logic [6:0]            NoteKey,
  input  logic [23:0]           NoteIncr,
  output logic [15:0]           BusAddress,
  output logic [7:0]            BusWriteData,
  output logic                  BusReadWrite,
  output logic                  BusClock,
  output logic [NUM_VOICES-1:0] VoiceActive
);

  localparam int unsigned VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned CW = (BUS_HALF > 1) ? $clog2(BUS_HALF) : 1;

  typedef enum logic [1:0] {IDLE, LOOKUP, WR_HI, WR_LO} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      cur_q, cur_d;     // write-list entry: 0 gate-off, 1..3 incr bytes, 4 gate-on
  logic [2:0]      last_q, last_d;
  logic [15:0]     base_q, base_d;
  logic [VW-1:0]   tgt_q, tgt_d;
  logic            cmd_on_q;
  logic [6:0]      cmd_key_q;
  logic [23:0]     cmd_incr_q;
  logic [VW-1:0]   steal_q;
  logic [6:0]      keys_q [NUM_VOICES];

  logic            accept, do_steal, write_done;
  logic [15:0]     addr_d;
  logic [7:0]      data_d;
  logic            rw_d, bclk_d;

  logic            match_hit, free_hit;
  logic [VW-1:0]   match_idx, free_idx;

  // Lowest-index active voice holding the command key, and lowest-index idle voice.
  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    for (int i = int'(NUM_VOICES) - 1; i >= 0; i--) begin
      if (VoiceActive[i] && (keys_q[i] == cmd_key_q)) begin
        match_hit = 1'b1;
        match_idx = VW'(i);
      end
      if (!VoiceActive[i]) begin
        free_hit = 1'b1;
        free_idx = VW'(i);
      end
    end
  end

  // Next state, write-list sequencing and next bus output values.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_d      = cur_q;
    last_d     = last_q;
    base_d     = base_q;
    tgt_d      = tgt_q;
    accept     = 1'b0;
    do_steal   = 1'b0;
    write_done = 1'b0;
    addr_d     = '0;
    data_d     = '0;
    rw_d       = 1'b0;
    bclk_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (NoteValid && NoteReady) begin
          accept  = 1'b1;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (cmd_on_q) begin
          state_d = WR_HI;
          cur_d   = 3'd1;
          last_d  = 3'd4;
          if (match_hit) begin
            tgt_d = match_idx;
            cur_d = 3'd0;
          end else if (free_hit) begin
            tgt_d = free_idx;
          end else begin
            tgt_d    = steal_q;
            cur_d    = 3'd0;
            do_steal = 1'b1;
          end
        end else if (match_hit) begin
          state_d = WR_HI;
          tgt_d   = match_idx;
          cur_d   = 3'd0;
          last_d  = 3'd0;
        end
        base_d = 16'(VOICE_BASE + 16'(tgt_d) * VOICE_STRIDE);
      end
      WR_HI: begin
        if (cnt_q == CW'(BUS_HALF - 1)) begin
          state_d = WR_LO;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WR_LO: begin
        if (cnt_q == CW'(BUS_HALF - 1)) begin
          write_done = 1'b1;
          cnt_d      = '0;
          if (cur_q == last_q) begin
            state_d = IDLE;
          end else begin
            state_d = WR_HI;
            cur_d   = cur_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are registered, so they follow the state being entered.
    if ((state_d == WR_HI) || (state_d == WR_LO)) begin
      rw_d   = 1'b1;
      bclk_d = (state_d == WR_HI);
      case (cur_d)
        3'd0:    begin addr_d = base_d;          data_d = 8'h00;              end
        3'd1:    begin addr_d = base_d + 16'd1;  data_d = cmd_incr_q[7:0];    end
        3'd2:    begin addr_d = base_d + 16'd2;  data_d = cmd_incr_q[15:8];   end
        3'd3:    begin addr_d = base_d + 16'd3;  data_d = cmd_incr_q[23:16];  end
        default: begin addr_d = base_d;          data_d = 8'h01;              end
      endcase
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      cur_q        <= '0;
      last_q       <= '0;
      base_q       <= '0;
      tgt_q        <= '0;
      cmd_on_q     <= 1'b0;
      cmd_key_q    <= '0;
      cmd_incr_q   <= '0;
      steal_q      <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) keys_q[i] <= '0;
      VoiceActive  <= '0;
      NoteReady    <= 1'b1;
      BusAddress   <= '0;
      BusWriteData <= '0;
      BusReadWrite <= 1'b0;
      BusClock     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_q        <= cur_d;
      last_q       <= last_d;
      base_q       <= base_d;
      tgt_q        <= tgt_d;
      NoteReady    <= (state_d == IDLE);
      BusAddress   <= addr_d;
      BusWriteData <= data_d;
      BusReadWrite <= rw_d;
      BusClock     <= bclk_d;
      if (accept) begin
        cmd_on_q   <= NoteOn;
        cmd_key_q  <= NoteKey;
        cmd_incr_q <= NoteIncr;
      end
      if ((state_q == LOOKUP) && cmd_on_q) keys_q[tgt_d] <= cmd_key_q;
      if (do_steal) steal_q <= (steal_q == VW'(NUM_VOICES - 1)) ? '0 : steal_q + VW'(1);
      // Gate flag follows the completed Gate register write.
      if (write_done && (cur_q == 3'd0)) VoiceActive[tgt_q] <= 1'b0;
      if (write_done && (cur_q == 3'd4)) VoiceActive[tgt_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed bench for voice_allocator (defaults:
// 4 voices, base 0x10, stride 0x20, 2-cycle bus half period).
module tb_voice_allocator;

  logic        Clock;
  logic        Reset;
  logic        NoteValid;
  logic        NoteReady;
  logic        NoteOn;
  logic [6:0]  NoteKey;
  logic [23:0] NoteIncr;
  logic [15:0] BusAddress;
  logic [7:0]  BusWriteData;
  logic        BusReadWrite;
  logic        BusClock;
  logic [3:0]  VoiceActive;

  voice_allocator dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .NoteValid    (NoteValid),
    .NoteReady    (NoteReady),
    .NoteOn       (NoteOn),
    .NoteKey      (NoteKey),
    .NoteIncr     (NoteIncr),
    .BusAddress   (BusAddress),
    .BusWriteData (BusWriteData),
    .BusReadWrite (BusReadWrite),
    .BusClock     (BusClock),
    .VoiceActive  (VoiceActive)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int vec  = 0;
  int miss = 0;

  // Capture of one command: writes seen, cycle NoteReady returned, framing errors.
  logic [15:0] cap_addr [8];
  logic [7:0]  cap_data [8];
  int          cap_n;
  int          ready_cyc;
  int          phase_err;
  int          idle_err;

  // Issue one command at a negedge and record the bus activity until NoteReady.
  // Cycle 0 is the accepting cycle; with poke set, NoteValid is pulsed while busy.
  task automatic run_cmd(input logic on, input logic [6:0] key, input logic [23:0] incr,
                         input logic poke);
    cap_n = 0; ready_cyc = -1; phase_err = 0; idle_err = 0;
    for (int i = 0; i < 8; i++) begin cap_addr[i] = 'x; cap_data[i] = 'x; end
    NoteValid = 1'b1; NoteOn = on; NoteKey = key; NoteIncr = incr;
    @(posedge Clock);
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge Clock);
      if (cyc == 1) NoteValid = 1'b0;
      if (poke && cyc == 3) begin NoteValid = 1'b1; NoteOn = 1'b1; NoteKey = 7'd100; end
      if (poke && cyc == 5) NoteValid = 1'b0;
      if (NoteReady === 1'b1) begin
        ready_cyc = cyc;
        if (BusClock !== 1'b0 || BusReadWrite !== 1'b0 || BusAddress !== 16'h0) idle_err++;
        break;
      end else if (cyc == 1) begin
        if (BusClock !== 1'b0 || BusReadWrite !== 1'b0 || BusAddress !== 16'h0 ||
            BusWriteData !== 8'h0) idle_err++;
      end else begin
        if (BusClock !== (((cyc - 2) % 4) < 2) || BusReadWrite !== 1'b1) phase_err++;
        if ((cyc - 2) % 4 == 0) begin
          if (cap_n < 8) begin
            cap_addr[cap_n] = BusAddress; cap_data[cap_n] = BusWriteData;
          end
          cap_n++;
        end else if (cap_n > 0 && cap_n <= 8 &&
                     (BusAddress !== cap_addr[cap_n-1] || BusWriteData !== cap_data[cap_n-1])) begin
          phase_err++;
        end
      end
    end
    NoteValid = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; NoteValid = 1'b0; NoteOn = 1'b0; NoteKey = '0; NoteIncr = '0;
    repeat (3) @(negedge Clock);
    vec++; if (NoteReady !== 1'b1) begin miss++; $display("FAIL reset_ready got %b want 1", NoteReady); end
    vec++; if (VoiceActive !== 4'b0000) begin miss++; $display("FAIL reset_active got %b want 0000", VoiceActive); end
    vec++; if (BusAddress !== 16'h0 || BusWriteData !== 8'h0 || BusReadWrite !== 1'b0 || BusClock !== 1'b0) begin
      miss++; $display("FAIL reset_bus got %h/%h/%b/%b want 0/0/0/0", BusAddress, BusWriteData, BusReadWrite, BusClock);
    end
    Reset = 1'b0;
    @(negedge Clock);
    vec++; if (NoteReady !== 1'b1) begin miss++; $display("FAIL reset_release_ready got %b want 1", NoteReady); end
  endtask

  task automatic test_note_on_first();
    logic [15:0] ea [4];
    logic [7:0]  ed [4];
    ea = '{16'h11, 16'h12, 16'h13, 16'h10};
    ed = '{8'hFF, 8'hFF, 8'h0F, 8'h01};
    run_cmd(1'b1, 7'd60, 24'h0FFFFF, 1'b0);
    vec++; if (cap_n !== 4) begin miss++; $display("FAIL on_first_count got %0d want 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
        miss++; $display("FAIL on_first_write%0d got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], ea[i], ed[i]);
      end
    end
    vec++; if (ready_cyc !== 18) begin miss++; $display("FAIL on_first_latency got %0d want 18", ready_cyc); end
    vec++; if (phase_err !== 0 || idle_err !== 0) begin miss++; $display("FAIL on_first_framing got %0d/%0d want 0/0", phase_err, idle_err); end
    vec++; if (VoiceActive !== 4'b0001) begin miss++; $display("FAIL on_first_active got %b want 0001", VoiceActive); end
  endtask

  task automatic test_note_off();
    run_cmd(1'b0, 7'd60, 24'h0, 1'b0);
    vec++; if (cap_n !== 1 || cap_addr[0] !== 16'h10 || cap_data[0] !== 8'h00) begin
      miss++; $display("FAIL off_write got n=%0d %h/%h want n=1 0010/00", cap_n, cap_addr[0], cap_data[0]);
    end
    vec++; if (ready_cyc !== 6) begin miss++; $display("FAIL off_latency got %0d want 6", ready_cyc); end
    vec++; if (phase_err !== 0 || idle_err !== 0) begin miss++; $display("FAIL off_framing got %0d/%0d want 0/0", phase_err, idle_err); end
    vec++; if (VoiceActive !== 4'b0000) begin miss++; $display("FAIL off_active got %b want 0000", VoiceActive); end
  endtask

  task automatic test_steal();
    logic [15:0] ea [5];
    logic [7:0]  ed [5];
    logic [15:0] gate_addr [4];
    gate_addr = '{16'h10, 16'h30, 16'h50, 16'h70};
    for (int v = 0; v < 4; v++) begin
      run_cmd(1'b1, 7'(60 + v), 24'h000100, 1'b0);
      vec++; if (cap_n !== 4 || cap_addr[3] !== gate_addr[v] || cap_data[3] !== 8'h01 || ready_cyc !== 18) begin
        miss++; $display("FAIL fill_voice%0d got n=%0d gate %h/%h lat %0d want n=4 gate %h/01 lat 18",
                         v, cap_n, cap_addr[3], cap_data[3], ready_cyc, gate_addr[v]);
      end
    end
    vec++; if (VoiceActive !== 4'b1111) begin miss++; $display("FAIL fill_active got %b want 1111", VoiceActive); end
    ea = '{16'h10, 16'h11, 16'h12, 16'h13, 16'h10};
    ed = '{8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01};
    run_cmd(1'b1, 7'd70, 24'h00FFFF, 1'b0);
    vec++; if (cap_n !== 5) begin miss++; $display("FAIL steal_count got %0d want 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      vec++; if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
        miss++; $display("FAIL steal_write%0d got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], ea[i], ed[i]);
      end
    end
    vec++; if (ready_cyc !== 22 || phase_err !== 0 || idle_err !== 0) begin
      miss++; $display("FAIL steal_timing got lat %0d err %0d/%0d want lat 22 err 0/0", ready_cyc, phase_err, idle_err);
    end
    vec++; if (VoiceActive !== 4'b1111) begin miss++; $display("FAIL steal_active got %b want 1111", VoiceActive); end
  endtask

  task automatic test_retrigger();
    logic [15:0] ea [5];
    logic [7:0]  ed [5];
    ea = '{16'h50, 16'h51, 16'h52, 16'h53, 16'h50};
    ed = '{8'h00, 8'h56, 8'h34, 8'h12, 8'h01};
    run_cmd(1'b1, 7'd62, 24'h123456, 1'b0);
    vec++; if (cap_n !== 5) begin miss++; $display("FAIL retrig_count got %0d want 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      vec++; if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
        miss++; $display("FAIL retrig_write%0d got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], ea[i], ed[i]);
      end
    end
    // Steal pointer still at voice 1; a busy-time NoteValid pulse must be dropped.
    ea = '{16'h30, 16'h31, 16'h32, 16'h33, 16'h30};
    ed = '{8'h00, 8'hEF, 8'hCD, 8'hAB, 8'h01};
    run_cmd(1'b1, 7'd80, 24'hABCDEF, 1'b1);
    vec++; if (cap_n !== 5) begin miss++; $display("FAIL steal2_count got %0d want 5", cap_n); end
    for (int i = 0; i < 5; i++) begin
      vec++; if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
        miss++; $display("FAIL steal2_write%0d got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], ea[i], ed[i]);
      end
    end
    vec++; if (ready_cyc !== 22) begin miss++; $display("FAIL busy_ignore_latency got %0d want 22", ready_cyc); end
    @(negedge Clock);
    vec++; if (NoteReady !== 1'b1 || BusClock !== 1'b0) begin
      miss++; $display("FAIL busy_ignore_idle got ready %b clk %b want 1 0", NoteReady, BusClock);
    end
  endtask

  task automatic test_no_match_and_free();
    run_cmd(1'b0, 7'd99, 24'h0, 1'b0);
    vec++; if (cap_n !== 0 || idle_err !== 0) begin miss++; $display("FAIL nomatch_writes got %0d/%0d want 0/0", cap_n, idle_err); end
    vec++; if (ready_cyc !== 2) begin miss++; $display("FAIL nomatch_latency got %0d want 2", ready_cyc); end
    vec++; if (VoiceActive !== 4'b1111) begin miss++; $display("FAIL nomatch_active got %b want 1111", VoiceActive); end
    run_cmd(1'b0, 7'd80, 24'h0, 1'b0);
    vec++; if (cap_n !== 1 || cap_addr[0] !== 16'h30 || cap_data[0] !== 8'h00 || VoiceActive !== 4'b1101) begin
      miss++; $display("FAIL off_voice1 got n=%0d %h/%h act %b want n=1 0030/00 act 1101", cap_n, cap_addr[0], cap_data[0], VoiceActive);
    end
    run_cmd(1'b1, 7'd90, 24'h030201, 1'b0);
    vec++; if (cap_n !== 4 || cap_addr[0] !== 16'h31 || cap_data[0] !== 8'h01 ||
               cap_addr[2] !== 16'h33 || cap_data[2] !== 8'h03 || cap_addr[3] !== 16'h30) begin
      miss++; $display("FAIL free_voice1 got n=%0d %h/%h %h/%h %h want n=4 0031/01 0033/03 0030",
                       cap_n, cap_addr[0], cap_data[0], cap_addr[2], cap_data[2], cap_addr[3]);
    end
    vec++; if (VoiceActive !== 4'b1111) begin miss++; $display("FAIL free_active got %b want 1111", VoiceActive); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ea [4];
    logic [7:0]  ed [4];
    // All voices busy, steal pointer at voice 2: third write is (0x52, incr[15:8]).
    NoteValid = 1'b1; NoteOn = 1'b1; NoteKey = 7'd5; NoteIncr = 24'h445566;
    @(posedge Clock);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge Clock);
      if (cyc == 1) NoteValid = 1'b0;
    end
    vec++; if (BusClock !== 1'b1 || BusAddress !== 16'h52 || BusWriteData !== 8'h55) begin
      miss++; $display("FAIL midwrite_bus got %b %h/%h want 1 0052/55", BusClock, BusAddress, BusWriteData);
    end
    Reset = 1'b1;
    @(negedge Clock);
    vec++; if (BusClock !== 1'b0 || BusAddress !== 16'h0 || BusReadWrite !== 1'b0 || VoiceActive !== 4'b0000) begin
      miss++; $display("FAIL midreset_state got %b %h %b %b want 0 0000 0 0000", BusClock, BusAddress, BusReadWrite, VoiceActive);
    end
    vec++; if (NoteReady !== 1'b1) begin miss++; $display("FAIL midreset_ready got %b want 1", NoteReady); end
    Reset = 1'b0;
    @(negedge Clock);
    ea = '{16'h11, 16'h12, 16'h13, 16'h10};
    ed = '{8'h01, 8'h00, 8'h00, 8'h01};
    run_cmd(1'b1, 7'd5, 24'h000001, 1'b0);
    vec++; if (cap_n !== 4) begin miss++; $display("FAIL postreset_count got %0d want 4", cap_n); end
    for (int i = 0; i < 4; i++) begin
      vec++; if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
        miss++; $display("FAIL postreset_write%0d got %h/%h want %h/%h", i, cap_addr[i], cap_data[i], ea[i], ed[i]);
      end
    end
    vec++; if (VoiceActive !== 4'b0001) begin miss++; $display("FAIL postreset_active got %b want 0001", VoiceActive); end
  endtask

  initial begin
    test_reset();
    test_note_on_first();
    test_note_off();
    test_steal();
    test_retrigger();
    test_no_match_and_free();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
